// File: rtl/decode_pipe.sv
`default_nettype none
// ============================================================================
// Module   : decode_pipe
// Brief    : RV32I decode stage with prioritised forwarding, load-use interlock
//            and a valid/ready registered output. DECODE_PERF_CNT_EN adds
//            perf_bubble/perf_flush/perf_stall saturating counters.
// Revision : 1.0 - initial release
// ============================================================================
module decode_pipe #(
   parameter int XLEN    = 32,
   parameter int REG_NUM = 32,
   parameter int FWD_N   = 3,
   parameter int PC_W    = 32
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               if_vld,
   output logic                               if_rdy,
   input  logic [31:0]                        if_inst,
   input  logic [PC_W-1:0]                    if_pc,
   input  logic                               flush,
   input  logic                               wb_we,
   input  logic [$clog2(REG_NUM)-1:0]         wb_wa,
   input  logic [XLEN-1:0]                    wb_dat,
   input  logic [FWD_N-1:0]                   fwd_we,
   input  logic [FWD_N-1:0]                   fwd_pend,
   input  logic [FWD_N*$clog2(REG_NUM)-1:0]   fwd_dst,
   input  logic [FWD_N*XLEN-1:0]              fwd_dat,
   output logic                               ex_vld,
   input  logic                               ex_rdy,
   output logic [31:0]                        ex_inst,
   output logic [PC_W-1:0]                    ex_pc,
   output logic [XLEN-1:0]                    ex_dat_a,
   output logic [XLEN-1:0]                    ex_dat_b,
   output logic [XLEN-1:0]                    ex_rd2,
   output logic [XLEN-1:0]                    ex_imm
`ifdef DECODE_PERF_CNT_EN
   ,
   output logic [31:0]                        perf_bubble,
   output logic [31:0]                        perf_flush,
   output logic [31:0]                        perf_stall
`endif
);

   localparam int          AW         = $clog2(REG_NUM);
   localparam logic [31:0] c_bubble   = 32'h0000_0013;
   localparam logic [6:0]  c_op_lui   = 7'b0110111;
   localparam logic [6:0]  c_op_auipc = 7'b0010111;
   localparam logic [6:0]  c_op_jal   = 7'b1101111;
   localparam logic [6:0]  c_op_jalr  = 7'b1100111;
   localparam logic [6:0]  c_op_br    = 7'b1100011;
   localparam logic [6:0]  c_op_load  = 7'b0000011;
   localparam logic [6:0]  c_op_store = 7'b0100011;
   localparam logic [6:0]  c_op_imm   = 7'b0010011;
   localparam logic [6:0]  c_op_rr    = 7'b0110011;

   logic [XLEN-1:0] r_rf [REG_NUM];
   logic            r_ex_vld;
   logic [31:0]     r_ex_inst;
   logic [PC_W-1:0] r_ex_pc;
   logic [XLEN-1:0] r_ex_dat_a, r_ex_dat_b, r_ex_rd2, r_ex_imm;

   logic [6:0]      w_op;
   logic [AW-1:0]   w_rs1, w_rs2;
   logic            w_use1, w_use2, w_hazard, w_ld;
   logic [XLEN:0]   w_op1, w_op2;
   logic [31:0]     w_imm32;
   logic [XLEN-1:0] w_imm;

   // Returns {pend, data}; the lowest-index matching source wins outright,
   // so a pending young producer is never masked by an older one.
   function automatic logic [XLEN:0] resolve(input logic [AW-1:0] rs);
      logic [XLEN:0] res;
      logic          hit;
      hit = 1'b0;
      res = {1'b0, r_rf[rs]};
      if (wb_we && wb_wa == rs && rs != '0) res = {1'b0, wb_dat};
      for (int i = 0; i < FWD_N; i++) begin
         if (!hit && fwd_we[i] && fwd_dst[i*AW +: AW] != '0 && fwd_dst[i*AW +: AW] == rs) begin
            hit = 1'b1;
            res = {fwd_pend[i], fwd_dat[i*XLEN +: XLEN]};
         end
      end
      return res;
   endfunction

   assign w_op  = if_inst[6:0];
   assign w_rs1 = if_inst[15 +: AW];
   assign w_rs2 = if_inst[20 +: AW];

   always_comb begin
      w_imm32 = {{20{if_inst[31]}}, if_inst[31:20]};
      case (w_op)
         c_op_lui, c_op_auipc: w_imm32 = {if_inst[31:12], 12'h000};
         c_op_store: w_imm32 = {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
         c_op_jal:   w_imm32 = {{11{if_inst[31]}}, if_inst[31], if_inst[19:12],
                                if_inst[20], if_inst[30:21], 1'b0};
         c_op_br:    w_imm32 = {{19{if_inst[31]}}, if_inst[31], if_inst[7],
                                if_inst[30:25], if_inst[11:8], 1'b0};
         default:    w_imm32 = {{20{if_inst[31]}}, if_inst[31:20]};
      endcase
   end

   assign w_imm  = {{(XLEN-31){w_imm32[31]}}, w_imm32[30:0]};
   assign w_use1 = (w_op == c_op_imm) || (w_op == c_op_rr) || (w_op == c_op_load) ||
                   (w_op == c_op_store) || (w_op == c_op_jalr) || (w_op == c_op_br);
   assign w_use2 = (w_op == c_op_rr) || (w_op == c_op_store) || (w_op == c_op_br);
   assign w_op1  = resolve(w_rs1);
   assign w_op2  = resolve(w_rs2);

   assign w_hazard = (w_use1 & w_op1[XLEN]) | (w_use2 & w_op2[XLEN]);
   assign w_ld     = ~r_ex_vld | ex_rdy;
   assign if_rdy   = rst_n & w_ld & ~w_hazard & ~flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_NUM; i++) r_rf[i] <= '0;
      end else if (wb_we && wb_wa != '0) begin
         r_rf[wb_wa] <= wb_dat;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ex_vld   <= 1'b0;
         r_ex_inst  <= c_bubble;
         r_ex_pc    <= '0;
         r_ex_dat_a <= '0;
         r_ex_dat_b <= '0;
         r_ex_rd2   <= '0;
         r_ex_imm   <= '0;
      end else if (flush) begin
         r_ex_vld   <= 1'b0;
         r_ex_inst  <= c_bubble;
      end else if (w_ld) begin
         if (if_vld && !w_hazard) begin
            r_ex_vld   <= 1'b1;
            r_ex_inst  <= if_inst;
            r_ex_pc    <= if_pc;
            r_ex_dat_a <= w_op1[XLEN-1:0];
            r_ex_dat_b <= (w_op == c_op_rr) ? w_op2[XLEN-1:0] : w_imm;
            r_ex_rd2   <= w_op2[XLEN-1:0];
            r_ex_imm   <= w_imm;
         end else begin
            r_ex_vld   <= 1'b0;
            r_ex_inst  <= c_bubble;
         end
      end
   end

   assign ex_vld   = r_ex_vld;
   assign ex_inst  = r_ex_inst;
   assign ex_pc    = r_ex_pc;
   assign ex_dat_a = r_ex_dat_a;
   assign ex_dat_b = r_ex_dat_b;
   assign ex_rd2   = r_ex_rd2;
   assign ex_imm   = r_ex_imm;

`ifdef DECODE_PERF_CNT_EN
   logic [31:0] r_perf_bubble, r_perf_flush, r_perf_stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_bubble <= '0;
         r_perf_flush  <= '0;
         r_perf_stall  <= '0;
      end else begin
         if (w_hazard && if_vld && w_ld && r_perf_bubble != '1) r_perf_bubble <= r_perf_bubble + 32'd1;
         if (flush && r_perf_flush != '1)                        r_perf_flush  <= r_perf_flush + 32'd1;
         if (r_ex_vld && !ex_rdy && r_perf_stall != '1)          r_perf_stall  <= r_perf_stall + 32'd1;
      end
   end

   assign perf_bubble = r_perf_bubble;
   assign perf_flush  = r_perf_flush;
   assign perf_stall  = r_perf_stall;
`endif

endmodule
`default_nettype wire
